// File: rtl/opb_s2p_pkg.sv
// Shared offsets, status bit positions and the ack-cycle access record for the
// fabric-to-PPC readback register block.
package opb_s2p_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_NEW = 0;
  localparam int ST_OVF = 1;

  // Describes the transfer being acknowledged; all-zero outside the ack cycle.
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       in_map;
    logic [1:0] idx;
  } opb_acc_t;

  function automatic logic [31:0] status_word(input logic nw, input logic ovf);
    logic [31:0] s;
    s         = '0;
    s[ST_NEW] = nw;
    s[ST_OVF] = ovf;
    return s;
  endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave front end: window decode, one registered ack per select assertion,
// and a registered description of the access for the ack cycle.
module opb_slave_ack
  import opb_s2p_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] BASEADDR = 32'h0100_8400,
  parameter logic [AW-1:0] HIGHADDR = 32'h0100_84FF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:AW-1] abus,
  input  logic          select,
  input  logic          rnw,
  output logic          issue,
  output logic          in_map,
  output logic [1:0]    idx,
  output logic          ack,
  output opb_acc_t      acc
);

  logic [AW-1:0] offset;
  logic          done;
  logic          unused_ok;

  assign offset    = abus - BASEADDR;
  assign in_map    = (offset[AW-1:4] == '0);
  assign idx       = offset[3:2];
  assign unused_ok = ^offset[1:0];

  // done stays set until select drops, so a master that holds select past
  // the ack never receives a second ack for the same transfer.
  assign issue = select && (abus >= BASEADDR) && (abus <= HIGHADDR) && !ack && !done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack  <= 1'b0;
      done <= 1'b0;
      acc  <= '0;
    end else begin
      ack  <= issue;
      done <= select && (done || ack);
      acc  <= issue ? opb_acc_t'{rd: rnw, wr: !rnw, in_map: in_map, idx: idx} : '0;
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PPC readback register: captures user words, keeps new/overflow
// flags and a capture counter, and exposes them through a 4-word OPB window.
module opb_register_simulink2ppc
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_8400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_84FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_frozen
);

  logic        issue, in_map, ack;
  logic [1:0]  idx;
  opb_acc_t    acc;
  logic [31:0] data_r, count_r, rdata, rd_mux;
  logic        new_r, ovf_r, freeze_r;
  logic        be3_q, wbit_q;
  logic        cap, clr_new, clr_ovf, wr_ctrl;
  logic        unused_ok;

  opb_slave_ack #(
    .AW       (C_OPB_AWIDTH),
    .BASEADDR (C_BASEADDR),
    .HIGHADDR (C_HIGHADDR)
  ) u_ack (
    .clk    (OPB_Clk),
    .rst    (OPB_Rst),
    .abus   (OPB_ABus),
    .select (OPB_select),
    .rnw    (OPB_RNW),
    .issue  (issue),
    .in_map (in_map),
    .idx    (idx),
    .ack    (ack),
    .acc    (acc)
  );

  always_comb begin
    rd_mux = '0;
    if (in_map) begin
      case (idx)
        OFF_DATA:   rd_mux = data_r;
        OFF_STATUS: rd_mux = status_word(new_r, ovf_r);
        OFF_COUNT:  rd_mux = count_r;
        default:    rd_mux = {31'd0, freeze_r};
      endcase
    end
  end

  assign cap     = user_data_valid && !freeze_r;
  assign clr_new = acc.rd && acc.in_map && (acc.idx == OFF_DATA);
  assign clr_ovf = acc.rd && acc.in_map && (acc.idx == OFF_STATUS);
  assign wr_ctrl = acc.wr && acc.in_map && (acc.idx == OFF_CTRL) && be3_q;

  // Read data is latched at the select edge and the clears land at the end of
  // the ack cycle, so a capture in the ack cycle keeps its new flag and does
  // not count as an overflow against the word just read.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_r   <= '0;
      count_r  <= '0;
      new_r    <= 1'b0;
      ovf_r    <= 1'b0;
      freeze_r <= 1'b0;
      rdata    <= '0;
      be3_q    <= 1'b0;
      wbit_q   <= 1'b0;
    end else begin
      rdata <= (issue && OPB_RNW) ? rd_mux : '0;
      if (issue) begin
        be3_q  <= OPB_BE[3];
        wbit_q <= OPB_DBus[C_OPB_DWIDTH-1];
      end
      if (cap) begin
        data_r  <= user_data_in;
        count_r <= count_r + 32'd1;
      end
      new_r <= cap || (new_r && !clr_new);
      ovf_r <= (ovf_r && !clr_ovf) || (cap && new_r && !clr_new);
      if (wr_ctrl) freeze_r <= wbit_q;
    end
  end

  assign Sl_DBus     = rdata;
  assign Sl_xferAck  = ack;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_frozen = freeze_r;

  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-2], (C_FAMILY == "virtex6")};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Randomized self-checking bench with a transaction-level model of the
// readback register (read-then-capture ordering inside one ack cycle).
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0100_8400;
  localparam logic [31:0] HIGH = 32'h0100_84FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        ack, err_ack, retry, tout;
  logic [31:0] udata = '0;
  logic        uvalid = 1'b0;
  logic        frozen;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_data, m_count;
  logic        m_new, m_ovf, m_freeze;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk         (clk),
    .OPB_Rst         (rst),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq),
    .Sl_DBus         (sl_dbus),
    .Sl_xferAck      (ack),
    .Sl_errAck       (err_ack),
    .Sl_retry        (retry),
    .Sl_toutSup      (tout),
    .user_data_in    (udata),
    .user_data_valid (uvalid),
    .user_frozen     (frozen)
  );

  // ---------------- reference model ----------------
  function automatic void mdl_reset();
    m_data = '0; m_count = '0; m_new = 0; m_ovf = 0; m_freeze = 0;
  endfunction

  function automatic bit is_hit(input logic [31:0] a);
    return (a >= BASE) && (a <= HIGH);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (is_hit(a) && (a - BASE) < 32'd16) begin
      case ((a - BASE) >> 2)
        0: begin v = m_data; m_new = 0; end
        1: begin v = {30'd0, m_ovf, m_new}; m_ovf = 0; end
        2: v = m_count;
        default: v = {31'd0, m_freeze};
      endcase
    end
    return v;
  endfunction

  function automatic void mdl_cap(input logic [31:0] w);
    if (!m_freeze) begin
      m_data  = w;
      m_count = m_count + 32'd1;
      if (m_new) m_ovf = 1;
      m_new = 1;
    end
  endfunction

  function automatic void mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [0:3] b);
    if (a == BASE + 32'hC && b[3]) m_freeze = d[0];
  endfunction

  // ---------------- bus drivers (no checking) ----------------
  // ap = {ack before select edge, ack in following cycle, ack one cycle later}
  task automatic bus_read(input logic [31:0] a, input bit cap, input logic [31:0] w,
                          output logic [31:0] d, output logic [2:0] ap);
    @(negedge clk);
    abus = a; rnw = 1'b1; sel = 1'b1;
    ap[2] = ack;
    @(negedge clk);
    sel = 1'b0;
    ap[1] = ack; d = sl_dbus;
    if (cap) begin uvalid = 1'b1; udata = w; end
    @(negedge clk);
    uvalid = 1'b0;
    ap[0] = ack;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [0:3] b,
                           output logic [2:0] ap);
    @(negedge clk);
    abus = a; rnw = 1'b0; sel = 1'b1; dbus = d; be = b;
    ap[2] = ack;
    @(negedge clk);
    sel = 1'b0;
    ap[1] = ack;
    @(negedge clk);
    ap[0] = ack;
  endtask

  task automatic strobe(input logic [31:0] w);
    @(negedge clk);
    uvalid = 1'b1; udata = w;
    @(negedge clk);
    uvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d, e;
    logic [2:0]  ap;
    mdl_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({ack, sl_dbus, frozen} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got ack=%b dbus=%h frozen=%b, want 0/0/0", ack, sl_dbus, frozen);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = mdl_rd(BASE + 32'(i * 4));
      bus_read(BASE + 32'(i * 4), 0, 0, d, ap);
      vectors++;
      if (d !== e || ap !== 3'b010) begin
        errors++; $display("FAIL reset_read[%0d]: got data=%h ack=%b, want data=%h ack=010", i, d, ap, e);
      end
    end
  endtask

  task automatic test_capture();
    logic [31:0] d, e;
    logic [2:0]  ap;
    logic [31:0] offs [4] = '{32'h4, 32'h0, 32'h4, 32'h8};
    strobe(32'hDEAD_BEEF); mdl_cap(32'hDEAD_BEEF);
    foreach (offs[i]) begin
      e = mdl_rd(BASE + offs[i]);
      bus_read(BASE + offs[i], 0, 0, d, ap);
      vectors++;
      if (d !== e || ap !== 3'b010) begin
        errors++; $display("FAIL capture_read[%0d]: got data=%h ack=%b, want data=%h ack=010", i, d, ap, e);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    logic [2:0]  ap;
    logic [31:0] offs [4] = '{32'h4, 32'h4, 32'h0, 32'h8};
    strobe(32'h1); mdl_cap(32'h1);
    strobe(32'h2); mdl_cap(32'h2);
    foreach (offs[i]) begin
      e = mdl_rd(BASE + offs[i]);
      bus_read(BASE + offs[i], 0, 0, d, ap);
      vectors++;
      if (d !== e) begin
        errors++; $display("FAIL overflow_read[%0d]: got %h, want %h", i, d, e);
      end
    end
  endtask

  task automatic test_freeze();
    logic [31:0] d, e;
    logic [2:0]  ap;
    bus_write(BASE + 32'hC, 32'h1, 4'b0001, ap); mdl_wr(BASE + 32'hC, 32'h1, 4'b0001);
    vectors++;
    if (ap !== 3'b010 || frozen !== m_freeze) begin
      errors++; $display("FAIL freeze_set: got ack=%b frozen=%b, want ack=010 frozen=%b", ap, frozen, m_freeze);
    end
    strobe(32'h55); mdl_cap(32'h55);
    for (int i = 0; i < 3; i++) begin
      e = mdl_rd(BASE + 32'(i * 4));
      bus_read(BASE + 32'(i * 4), 0, 0, d, ap);
      vectors++;
      if (d !== e) begin
        errors++; $display("FAIL frozen_read[%0d]: got %h, want %h", i, d, e);
      end
    end
    bus_write(BASE + 32'hC, 32'h0, 4'b1110, ap); mdl_wr(BASE + 32'hC, 32'h0, 4'b1110);
    e = mdl_rd(BASE + 32'hC);
    bus_read(BASE + 32'hC, 0, 0, d, ap);
    vectors++;
    if (d !== e || frozen !== m_freeze) begin
      errors++; $display("FAIL freeze_be_masked: got ctrl=%h frozen=%b, want ctrl=%h frozen=%b", d, frozen, e, m_freeze);
    end
    bus_write(BASE + 32'hC, 32'h0, 4'b0001, ap); mdl_wr(BASE + 32'hC, 32'h0, 4'b0001);
    vectors++;
    if (frozen !== m_freeze) begin
      errors++; $display("FAIL freeze_clear: got %b, want %b", frozen, m_freeze);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d, e;
    logic [2:0]  ap;
    e = mdl_rd(BASE); bus_read(BASE, 0, 0, d, ap);
    e = mdl_rd(BASE + 32'h4); bus_read(BASE + 32'h4, 0, 0, d, ap);
    strobe(32'h11); mdl_cap(32'h11);
    // capture in the DATA-read ack cycle
    e = mdl_rd(BASE); mdl_cap(32'hA5);
    bus_read(BASE, 1, 32'hA5, d, ap);
    vectors++;
    if (d !== e) begin
      errors++; $display("FAIL collide_data: got %h, want %h", d, e);
    end
    e = mdl_rd(BASE + 32'h4); bus_read(BASE + 32'h4, 0, 0, d, ap);
    vectors++;
    if (d !== e) begin
      errors++; $display("FAIL collide_data_flags: got %h, want %h", d, e);
    end
    // new is 1 again; overflow-setting capture in the STATUS-read ack cycle
    e = mdl_rd(BASE + 32'h4); mdl_cap(32'h77);
    bus_read(BASE + 32'h4, 1, 32'h77, d, ap);
    vectors++;
    if (d !== e) begin
      errors++; $display("FAIL collide_status: got %h, want %h", d, e);
    end
    e = mdl_rd(BASE + 32'h4); bus_read(BASE + 32'h4, 0, 0, d, ap);
    vectors++;
    if (d !== e) begin
      errors++; $display("FAIL collide_status_after: got %h, want %h", d, e);
    end
  endtask

  task automatic test_count_wrap();
    logic [31:0] d, e;
    logic [2:0]  ap;
    @(negedge clk);
    force dut.count_r = 32'hFFFF_FFFF;
    #1 release dut.count_r;
    m_count = 32'hFFFF_FFFF;
    e = mdl_rd(BASE + 32'h8); bus_read(BASE + 32'h8, 0, 0, d, ap);
    vectors++;
    if (d !== e) begin
      errors++; $display("FAIL count_preload: got %h, want %h", d, e);
    end
    strobe(32'hCAFE); mdl_cap(32'hCAFE);
    e = mdl_rd(BASE + 32'h8); bus_read(BASE + 32'h8, 0, 0, d, ap);
    vectors++;
    if (d !== e) begin
      errors++; $display("FAIL count_wrap: got %h, want %h", d, e);
    end
  endtask

  task automatic test_select_hold();
    logic [31:0] d, e;
    logic [2:0]  ap;
    int          n;
    logic [31:0] addrs [3] = '{32'h0100_8410, 32'h0100_8500, 32'h0100_83FC};
    n = 0;
    @(negedge clk);
    abus = BASE + 32'hC; rnw = 1'b1; sel = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack) n++;
      if (c == 2) sel = 1'b0;
    end
    vectors++;
    if (n !== 1) begin
      errors++; $display("FAIL select_hold: got %0d acks, want 1", n);
    end
    foreach (addrs[i]) begin
      e = mdl_rd(addrs[i]);
      bus_read(addrs[i], 0, 0, d, ap);
      vectors++;
      if (d !== e || ap !== (is_hit(addrs[i]) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL addr_decode[%h]: got data=%h ack=%b, want data=%h hit=%b", addrs[i], d, ap, e, is_hit(addrs[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, e, a, w;
    logic [2:0]  ap;
    logic [0:3]  b;
    logic [31:0] pool [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h24, 32'h100};
    bit          cap;
    for (int k = 0; k < 80; k++) begin
      a = BASE + pool[$urandom_range(0, 6)];
      case ($urandom_range(0, 3))
        0, 1: begin
          w = $urandom(); cap = 1'($urandom_range(0, 1));
          e = mdl_rd(a);
          if (cap) mdl_cap(w);
          bus_read(a, cap, w, d, ap);
          vectors++;
          if (d !== e || ap !== (is_hit(a) ? 3'b010 : 3'b000)) begin
            errors++; $display("FAIL rand_read[%0d] @%h: got data=%h ack=%b, want data=%h", k, a, d, ap, e);
          end
        end
        2: begin
          w = $urandom(); strobe(w); mdl_cap(w);
        end
        default: begin
          w = $urandom(); b = 4'($urandom());
          if ($urandom_range(0, 1) == 1) a = BASE + 32'hC;
          bus_write(a, w, b, ap); mdl_wr(a, w, b);
          vectors++;
          if (frozen !== m_freeze) begin
            errors++; $display("FAIL rand_write[%0d] @%h: got frozen=%b, want %b", k, a, frozen, m_freeze);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ap;
    bus_write(BASE + 32'hC, 32'h1, 4'b0001, ap); mdl_wr(BASE + 32'hC, 32'h1, 4'b0001);
    @(negedge clk);
    abus = BASE; rnw = 1'b1; sel = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    mdl_reset();
    vectors++;
    if (ack !== 1'b0 || sl_dbus !== '0 || frozen !== m_freeze) begin
      errors++; $display("FAIL reset_mid: got ack=%b dbus=%h frozen=%b, want 0/0/%b", ack, sl_dbus, frozen, m_freeze);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_freeze();
    test_collision();
    test_count_wrap();
    test_select_hold();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
